// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants, coordinate widths and flag decode helpers.
// Consumed by the sync generator and by the per-object drawing comparators.
package vga_timing_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;

    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned H_TOTAL      = H_SYNC_END + H_BACK;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam int unsigned V_TOTAL      = V_SYNC_END + V_BACK;

    localparam int unsigned X_W   = 10;
    localparam int unsigned Y_W   = 9;
    localparam int unsigned CNT_W = 10;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
    } sync_flags_t;

    // Sync pulses are active low; active marks the visible 640x480 window.
    function automatic sync_flags_t decode_flags(input logic [CNT_W-1:0] h,
                                                 input logic [CNT_W-1:0] v);
        sync_flags_t f;
        f.hsync  = !((h >= CNT_W'(H_SYNC_START)) && (h < CNT_W'(H_SYNC_END)));
        f.vsync  = !((v >= CNT_W'(V_SYNC_START)) && (v < CNT_W'(V_SYNC_END)));
        f.active = (h < CNT_W'(H_VISIBLE)) && (v < CNT_W'(V_VISIBLE));
        return f;
    endfunction

    // Drawing logic sees row 0 throughout vertical blanking.
    function automatic logic [Y_W-1:0] row_of(input logic [CNT_W-1:0] v);
        return (v < CNT_W'(V_VISIBLE)) ? v[Y_W-1:0] : '0;
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the board clock by CLK_DIV (1..8) into a one-clock pixel advance pulse.
// tick_c is the combinational advance for same-edge use; pixelTick is its registered copy.
module pixel_tick_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_c,
    output logic pixelTick
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        tick_c = (div_q == DIV_W'(CLK_DIV - 1));
        div_d  = tick_c ? '0 : div_q + DIV_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            pixelTick <= 1'b0;
        end else begin
            div_q     <= div_d;
            pixelTick <= tick_c;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// 640x480@60 raster generator: sync, display-area flag and current pixel coordinate.
// Define VGA_SYNC_FRAME_TICK_EN to add frameTick, pulsed on the (799,524)->(0,0) wrap.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic [X_W-1:0] CounterX,
    output logic [Y_W-1:0] CounterY,
    output logic           hsync,
    output logic           vsync,
    output logic           inDisplayArea,
`ifdef VGA_SYNC_FRAME_TICK_EN
    output logic           frameTick,
`endif
    output logic           pixelTick
);

    logic             tick_c;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic [CNT_W-1:0] hcount_d;
    logic [CNT_W-1:0] vcount_d;
    logic             h_wrap_c;
    logic             v_wrap_c;
    sync_flags_t      flags_d;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_c    (tick_c),
        .pixelTick (pixelTick)
    );

    // Next raster position; flags decode the next position so they land with the coordinate.
    always_comb begin
        h_wrap_c = (hcount == CNT_W'(H_TOTAL - 1));
        v_wrap_c = (vcount == CNT_W'(V_TOTAL - 1));
        hcount_d = hcount;
        vcount_d = vcount;
        if (tick_c) begin
            hcount_d = h_wrap_c ? '0 : hcount + CNT_W'(1);
            if (h_wrap_c) begin
                vcount_d = v_wrap_c ? '0 : vcount + CNT_W'(1);
            end
        end
        flags_d = decode_flags(hcount_d, vcount_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount        <= '0;
            vcount        <= '0;
            CounterY      <= '0;
            hsync         <= 1'b1;
            vsync         <= 1'b1;
            inDisplayArea <= 1'b0;
        end else if (tick_c) begin
            hcount        <= hcount_d;
            vcount        <= vcount_d;
            CounterY      <= row_of(vcount_d);
            hsync         <= flags_d.hsync;
            vsync         <= flags_d.vsync;
            inDisplayArea <= flags_d.active;
        end
    end

    assign CounterX = hcount;

`ifdef VGA_SYNC_FRAME_TICK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frameTick <= 1'b0;
        end else begin
            frameTick <= tick_c && h_wrap_c && v_wrap_c;
        end
    end
`endif

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates the 640x480@60 Hz VGA raster: horizontal/vertical sync, a display-area flag, and the current pixel coordinate (CounterX, CounterY) that every shape-drawing comparator in the game consumes. Sits between the board clock and the per-object drawing logic and colour mux. It is the single source of raster position for the whole video path.

## Interface
- CLK_DIV, 2: board clocks per pixel (50 MHz / 2 = 25 MHz pixel rate); legal 1..8
- clk  input  1  board clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- CounterX  output  10  current pixel column, 0..799
- CounterY  output  9  current pixel row, 0..479 in vertical display; 0 during vertical blanking
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- inDisplayArea  output  1  high when (CounterX<640) and (row<480)
- pixelTick  output  1  one-clk pulse each pixel advance
- frameTick  output  1  present only with VGA_SYNC_FRAME_TICK_EN

## Operation
- Sub-divider produces pixelTick once every CLK_DIV clocks (CLK_DIV=1: every clock).
- Internal hcount (10 b) and vcount (10 b); CounterX = hcount, CounterY = vcount[8:0] when vcount<480 else 0.
- On pixelTick: hcount increments; at 799 wraps to 0 and vcount increments; vcount wraps 524 -> 0 on the same tick hcount wraps.
- Horizontal: visible 0..639, front porch 640..655, sync 656..751 (hsync=0), back porch 752..799.
- Vertical: visible 0..479, front porch 480..489, sync 490..491 (vsync=0), back porch 492..524.
- hsync, vsync, inDisplayArea registered, decoded from next counter values, so they change on the same edge as CounterX/CounterY (zero skew between coordinate and flags).
- Reset values: hcount=0, vcount=0, divider=0, hsync=1, vsync=1, inDisplayArea=0, pixelTick=0, frameTick=0.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronous); after release, raster restarts at (0,0) — first frame's pixel (0,0) is blanked.

## Timing
- First pixelTick at CLK_DIV clocks after rst_n release (clock CLK_DIV-1 counting from 0); moves position to (1,0) with inDisplayArea=1.
- Line = 800 ticks; frame = 800*525 = 420000 ticks (840000 clk at CLK_DIV=2).
- hsync low 96 ticks per line; vsync low exactly 1600 ticks (2 full lines), falling on the tick hcount wraps into vcount=490.
- inDisplayArea high 640 ticks per visible line, 307200 ticks per frame.
- Between ticks all outputs hold.

## Configuration
- VGA_SYNC_FRAME_TICK_EN defined: frameTick port exists; one-clk pulse coincident with the pixelTick that wraps (799,524) -> (0,0). Used by game logic to update object positions once per frame.
- Undefined: no frameTick port, no associated logic; all other behaviour identical.

## Structure
- Shared package vga_timing_pkg: H_VISIBLE=640, H_FRONT=16, H_SYNC=96, H_BACK=48, H_TOTAL=800, V_VISIBLE=480, V_FRONT=10, V_SYNC=2, V_BACK=33, V_TOTAL=525, and coordinate widths (X 10 b, Y 9 b) shared with the drawing comparators.
- One sub-module: pixel_tick_gen (CLK_DIV counter, async active-low reset, outputs pixelTick).

## Test plan
- Reset held 10 clk then released -> during reset hsync=1, vsync=1, inDisplayArea=0, CounterX=0, CounterY=0; first pixelTick at clock 2 (CLK_DIV=2), CounterX=1.
- Run one line -> successive hsync falling edges exactly 1600 clk apart; hsync low 192 clk; falling edge when CounterX becomes 656.
- Run two frames -> vsync low 3200 clk, falling edges 840000 clk apart; inDisplayArea high 307200 ticks per frame; CounterY never exceeds 479 and reads 0 for vcount 480..524.
- Wrap check -> tick at (799,524) yields (0,0), inDisplayArea=1, frameTick=1 for one clk (macro defined); with macro undefined port absent, elaboration clean.
- Assert rst_n at (300,200) mid-line -> outputs reset asynchronously same cycle; after release raster restarts from (0,0), next hsync falling edge 655*2 clk after first tick.
- CLK_DIV=1 -> pixelTick every clk, line = 800 clk, frame = 420000 clk.
